mpmc12_resp_burst_tracker: RTL and testbench

Multi-channel successor to the single-burst response counter in the multi-port memory controller. It queues up to DEPTH outstanding read bursts, each tagged with a channel ID and length, in issue order. It counts returning response beats against the head burst and tags every beat with channel, beat index and last flag. It pulses completion per burst and flags protocol errors, so the read-data steering logic no longer depends on controller state.

---
 rtl/mpmc12_resp_burst_tracker.sv | 138 +++++++++++++
 tb/tb_mpmc12_resp_burst_tracker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mpmc12_resp_burst_tracker.sv
// mpmc12_resp_burst_tracker
//   Tracks up to DEPTH outstanding read bursts in issue order and tags every
//   returning response beat with its channel, beat index and last flag, so the
//   read-data steering logic needs no knowledge of controller state.
//
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   clear              synchronous flush, same effect as reset
//   req_valid/ready    burst issue handshake (ready == !full)
//   req_ch, req_len    channel and length (beats-1) of the issued burst
//   resp_valid         one response beat returned (no backpressure)
//   beat_*             registered beat tag, one cycle after acceptance
//   burst_done[_ch]    one-cycle completion pulse and its channel
//   busy, outstanding  queue occupancy
//   err_unexp, err_ovf sticky protocol errors (beat on empty / push on full)
module mpmc12_resp_burst_tracker #(
    parameter int NCH   = 8,
    parameter int BW    = 8,
    parameter int DEPTH = 4,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           clear,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [CHW-1:0] req_ch,
    input  logic [BW-1:0]  req_len,
    input  logic           resp_valid,
    output logic           beat_valid,
    output logic [CHW-1:0] beat_ch,
    output logic [BW-1:0]  beat_idx,
    output logic           beat_last,
    output logic           burst_done,
    output logic [CHW-1:0] burst_done_ch,
    output logic           busy,
    output logic [AW:0]    outstanding,
    output logic           err_unexp,
    output logic           err_ovf
);

    // Queue storage; contents need no reset because the pointers gate access.
    logic [CHW-1:0] ch_mem_q  [DEPTH];
    logic [BW-1:0]  len_mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]  cnt_q, cnt_d;

    logic           beat_valid_q, beat_last_q, burst_done_q;
    logic [CHW-1:0] beat_ch_q, burst_done_ch_q;
    logic [BW-1:0]  beat_idx_q;
    logic           err_unexp_q, err_ovf_q;

    logic           flush, empty, full, push, accept, last;
    logic [CHW-1:0] head_ch;
    logic [BW-1:0]  head_len;

    assign flush    = !rstn || clear;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_ch  = ch_mem_q[rd_ptr_q[AW-1:0]];
    assign head_len = len_mem_q[rd_ptr_q[AW-1:0]];

    // Full is judged before any same-cycle pop: no bypass into a freed slot.
    assign push     = req_valid && !full;
    assign accept   = resp_valid && !empty;
    assign last     = (cnt_q == head_len);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (accept) begin
            if (last) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d    = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            ch_mem_q[wr_ptr_q[AW-1:0]]  <= req_ch;
            len_mem_q[wr_ptr_q[AW-1:0]] <= req_len;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            cnt_q           <= '0;
            beat_valid_q    <= 1'b0;
            beat_ch_q       <= '0;
            beat_idx_q      <= '0;
            beat_last_q     <= 1'b0;
            burst_done_q    <= 1'b0;
            burst_done_ch_q <= '0;
            err_unexp_q     <= 1'b0;
            err_ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            beat_valid_q <= accept;
            burst_done_q <= accept && last;
            // Tags hold their last accepted value between beats.
            if (accept) begin
                beat_ch_q   <= head_ch;
                beat_idx_q  <= cnt_q;
                beat_last_q <= last;
                if (last) burst_done_ch_q <= head_ch;
            end
            if (resp_valid && empty) err_unexp_q <= 1'b1;
            if (req_valid && full)   err_ovf_q   <= 1'b1;
        end
    end

    assign req_ready     = !full;
    assign busy          = !empty;
    assign outstanding   = wr_ptr_q - rd_ptr_q;
    assign beat_valid    = beat_valid_q;
    assign beat_ch       = beat_ch_q;
    assign beat_idx      = beat_idx_q;
    assign beat_last     = beat_last_q;
    assign burst_done    = burst_done_q;
    assign burst_done_ch = burst_done_ch_q;
    assign err_unexp     = err_unexp_q;
    assign err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_mpmc12_resp_burst_tracker.sv
// Directed bench for mpmc12_resp_burst_tracker (NCH=8, BW=8, DEPTH=4).
module tb_mpmc12_resp_burst_tracker;

    logic       clk = 1'b0;
    logic       rstn, clear, req_valid, resp_valid;
    logic [2:0] req_ch;
    logic [7:0] req_len;
    logic       req_ready, beat_valid, beat_last, burst_done, busy;
    logic [2:0] beat_ch, burst_done_ch, outstanding;
    logic [7:0] beat_idx;
    logic       err_unexp, err_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mpmc12_resp_burst_tracker #(.NCH(8), .BW(8), .DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_len(req_len),
        .resp_valid(resp_valid),
        .beat_valid(beat_valid), .beat_ch(beat_ch), .beat_idx(beat_idx),
        .beat_last(beat_last), .burst_done(burst_done),
        .burst_done_ch(burst_done_ch), .busy(busy),
        .outstanding(outstanding),
        .err_unexp(err_unexp), .err_ovf(err_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic rv, input int ch, input int len, input logic sv);
        req_valid  = rv;
        req_ch     = 3'(ch);
        req_len    = 8'(len);
        resp_valid = sv;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        resp_valid = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input int ch, input int idx, input logic lst);
        chk({tag, ".valid"}, 32'(beat_valid), 32'(1));
        chk({tag, ".ch"},    32'(beat_ch),    32'(ch));
        chk({tag, ".idx"},   32'(beat_idx),   32'(idx));
        chk({tag, ".last"},  32'(beat_last),  32'(lst));
        chk({tag, ".done"},  32'(burst_done), 32'(lst));
        if (lst) chk({tag, ".done_ch"}, 32'(burst_done_ch), 32'(ch));
    endtask

    task automatic chk_idle(input string tag, input int outs, input logic eu, input logic eo);
        chk({tag, ".valid"}, 32'(beat_valid),  32'(0));
        chk({tag, ".done"},  32'(burst_done),  32'(0));
        chk({tag, ".outs"},  32'(outstanding), 32'(outs));
        chk({tag, ".busy"},  32'(busy),        32'(outs != 0));
        chk({tag, ".rdy"},   32'(req_ready),   32'(outs != 4));
        chk({tag, ".eu"},    32'(err_unexp),   32'(eu));
        chk({tag, ".eo"},    32'(err_ovf),     32'(eo));
    endtask

    int exp_ch  [4] = '{1, 5, 5, 5};
    int exp_idx [4] = '{0, 0, 1, 2};
    int exp_lst [4] = '{1, 0, 0, 1};

    initial begin
        rstn = 1'b0; clear = 1'b0;
        req_valid = 1'b0; resp_valid = 1'b0; req_ch = '0; req_len = '0;
        cyc(0, 0, 0, 0);
        cyc(1, 2, 2, 1);        // reset overrides req/resp
        rstn = 1'b1;
        chk_idle("rst", 0, 0, 0);
        chk("rst.ch",  32'(beat_ch),  32'(0));
        chk("rst.idx", 32'(beat_idx), 32'(0));
        chk("rst.last", 32'(beat_last), 32'(0));
        chk("rst.dch", 32'(burst_done_ch), 32'(0));

        // 1: single 4-beat burst
        cyc(1, 3, 3, 0);
        chk_idle("t1.push", 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1);
            chk_beat($sformatf("t1.b%0d", i), 3, i, i == 3);
            chk("t1.outs", 32'(outstanding), (i == 3) ? 32'(0) : 32'(1));
        end
        cyc(0, 0, 0, 0);
        chk_idle("t1.idle", 0, 0, 0);
        chk("t1.hold_idx", 32'(beat_idx), 32'(3));
        chk("t1.hold_ch",  32'(beat_ch),  32'(3));

        // 2: len=0 burst followed by len=2 burst, no bubble
        cyc(1, 1, 0, 0);
        cyc(1, 5, 2, 0);
        chk_idle("t2.push", 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1);
            chk_beat($sformatf("t2.b%0d", i), exp_ch[i], exp_idx[i], exp_lst[i] != 0);
        end
        chk("t2.outs", 32'(outstanding), 32'(0));

        // 3: fill, overflow, pop under full, then push+pop
        cyc(1, 0, 1, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 2, 0, 0);
        cyc(1, 3, 0, 0);
        chk_idle("t3.full", 4, 0, 0);
        cyc(1, 7, 0, 0);
        chk_idle("t3.ovf", 4, 0, 1);
        cyc(0, 0, 0, 1);
        chk_beat("t3.b0", 0, 0, 0);
        chk("t3.outs0", 32'(outstanding), 32'(4));
        cyc(1, 6, 0, 1);        // full before pop: push rejected
        chk_beat("t3.b1", 0, 1, 1);
        chk("t3.outs1", 32'(outstanding), 32'(3));
        chk("t3.rdy1",  32'(req_ready),   32'(1));
        cyc(1, 6, 0, 1);        // push and pop together
        chk_beat("t3.b2", 1, 0, 1);
        chk("t3.outs2", 32'(outstanding), 32'(3));
        cyc(0, 0, 0, 1); chk_beat("t3.b3", 2, 0, 1);
        cyc(0, 0, 0, 1); chk_beat("t3.b4", 3, 0, 1);
        cyc(0, 0, 0, 1); chk_beat("t3.b5", 6, 0, 1);
        cyc(0, 0, 0, 0);
        chk_idle("t3.end", 0, 0, 1);

        // 4: unexpected beats
        clear = 1'b1; cyc(0, 0, 0, 0); clear = 1'b0;
        chk_idle("t4.clr", 0, 0, 0);
        chk("t4.clr_idx", 32'(beat_idx), 32'(0));
        cyc(0, 0, 0, 1);
        chk_idle("t4.empty", 0, 1, 0);
        clear = 1'b1; cyc(0, 0, 0, 0); clear = 1'b0;
        cyc(1, 4, 1, 1);        // beat in the push cycle is dropped
        chk_idle("t4.pushcyc", 1, 1, 0);
        cyc(0, 0, 0, 1); chk_beat("t4.b0", 4, 0, 0);
        cyc(0, 0, 0, 1); chk_beat("t4.b1", 4, 1, 1);
        chk("t4.eu_held", 32'(err_unexp), 32'(1));

        // 5: maximum length, 256 beats
        clear = 1'b1; cyc(0, 0, 0, 0); clear = 1'b0;
        cyc(1, 2, 255, 0);
        for (int i = 0; i < 256; i++) begin
            cyc(0, 0, 0, 1);
            chk_beat($sformatf("t5.b%0d", i), 2, i, i == 255);
        end
        cyc(0, 0, 0, 0);
        chk_idle("t5.end", 0, 0, 0);

        // 6a: clear mid-burst, overriding simultaneous req/resp
        cyc(0, 0, 0, 1);
        cyc(1, 5, 7, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1);
            chk_beat($sformatf("t6a.b%0d", i), 5, i, 0);
        end
        clear = 1'b1; cyc(1, 1, 1, 1); clear = 1'b0;
        chk_idle("t6a.clr", 0, 0, 0);
        chk("t6a.idx", 32'(beat_idx), 32'(0));
        chk("t6a.ch",  32'(beat_ch),  32'(0));
        cyc(1, 6, 1, 0);
        cyc(0, 0, 0, 1); chk_beat("t6a.n0", 6, 0, 0);
        cyc(0, 0, 0, 1); chk_beat("t6a.n1", 6, 1, 1);

        // 6b: reset mid-burst
        cyc(1, 5, 7, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1);
            chk_beat($sformatf("t6b.b%0d", i), 5, i, 0);
        end
        cyc(1, 0, 0, 0);        // extra push so reset has more to flush
        chk("t6b.outs", 32'(outstanding), 32'(2));
        rstn = 1'b0; cyc(0, 0, 0, 1); rstn = 1'b1;
        chk_idle("t6b.rst", 0, 0, 0);
        chk("t6b.idx", 32'(beat_idx), 32'(0));
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 1); chk_beat("t6b.n0", 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
